// File: rtl/branch_recovery_queue_if.sv
// Bundles the allocate, resolve and flush/retire signals of the
// branch recovery queue.
//   master : fetch/predictor and EX side (drives alloc_* and resolve_*)
//   slave  : the queue itself (drives alloc_ready/tag, flush, recover_pc,
//            flush_tag, retire_*, count)
interface branch_recovery_queue_if #(
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4
);
  localparam int TAG_W = $clog2(DEPTH);

  logic                alloc_valid;
  logic [PC_WIDTH-1:0] alloc_pc;
  logic                alloc_pred_taken;
  logic [PC_WIDTH-1:0] alloc_pred_target;
  logic                alloc_ready;
  logic [TAG_W-1:0]    alloc_tag;

  logic                resolve_valid;
  logic [TAG_W-1:0]    resolve_tag;
  logic                resolve_taken;
  logic [PC_WIDTH-1:0] resolve_target;

  logic                flush;
  logic [PC_WIDTH-1:0] recover_pc;
  logic [TAG_W-1:0]    flush_tag;
  logic                retire_valid;
  logic [TAG_W-1:0]    retire_tag;
  logic [TAG_W:0]      count;

  modport master (
    output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
    output resolve_valid, resolve_tag, resolve_taken, resolve_target,
    input  alloc_ready, alloc_tag, flush, recover_pc, flush_tag,
    input  retire_valid, retire_tag, count
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
    input  resolve_valid, resolve_tag, resolve_taken, resolve_target,
    output alloc_ready, alloc_tag, flush, recover_pc, flush_tag,
    output retire_valid, retire_tag, count
  );
endinterface

// File: rtl/branch_recovery_queue.sv
// Tracks up to DEPTH in-flight predicted branches in program order, checks
// each out-of-order resolution against its prediction, raises a one-cycle
// flush with the recovery PC on a mispredict (squashing younger entries),
// and retires resolved entries in order from the head.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : branch_recovery_queue_if.slave (allocate, resolve, flush, retire, count)
module branch_recovery_queue #(
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4
) (
  input logic                    clk,
  input logic                    reset,
  branch_recovery_queue_if.slave bus
);
  localparam int TAG_W = $clog2(DEPTH);

  logic [DEPTH-1:0]    ent_valid, ent_resolved, ent_pred_taken;
  logic [PC_WIDTH-1:0] ent_pc     [DEPTH];
  logic [PC_WIDTH-1:0] ent_target [DEPTH];

  logic [TAG_W-1:0]    head, tail;
  logic [TAG_W:0]      count_q;
  logic                flush_q;
  logic [PC_WIDTH-1:0] recover_q;
  logic [TAG_W-1:0]    flush_tag_q;
  logic                retire_valid_q;
  logic [TAG_W-1:0]    retire_tag_q;

  logic                alloc_ready;
  logic                do_alloc, res_hit, mispredict, do_retire;
  logic                sel_pred_taken;
  logic [PC_WIDTH-1:0] sel_pc, sel_target;
  logic [TAG_W-1:0]    res_age;
  logic [TAG_W-1:0]    age [DEPTH];
  logic [DEPTH-1:0]    valid_n, resolved_n;
  logic [TAG_W-1:0]    head_n, tail_n;
  logic [TAG_W:0]      count_n;

  assign alloc_ready = (count_q < (TAG_W+1)'(DEPTH)) && !flush_q;
  assign do_alloc    = bus.alloc_valid && alloc_ready;

  assign sel_pred_taken = ent_pred_taken[bus.resolve_tag];
  assign sel_pc         = ent_pc[bus.resolve_tag];
  assign sel_target     = ent_target[bus.resolve_tag];

  // Resolves for empty, squashed or already-resolved slots are stale; drop them.
  assign res_hit = bus.resolve_valid && ent_valid[bus.resolve_tag] &&
                   !ent_resolved[bus.resolve_tag];
  assign mispredict = res_hit &&
                      ((sel_pred_taken != bus.resolve_taken) ||
                       (sel_pred_taken && bus.resolve_taken &&
                        (sel_target != bus.resolve_target)));

  // Retirement looks at registered state only, so a head resolved this cycle
  // retires at the next edge at the earliest.
  assign do_retire = ent_valid[head] && ent_resolved[head];

  // Program-order age relative to the head; larger age means younger.
  assign res_age = bus.resolve_tag - head;
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    assign age[g] = TAG_W'(g) - head;
  end

  always_comb begin
    valid_n    = ent_valid;
    resolved_n = ent_resolved;
    if (do_alloc && !mispredict) begin
      valid_n[tail]    = 1'b1;
      resolved_n[tail] = 1'b0;
    end
    if (res_hit) resolved_n[bus.resolve_tag] = 1'b1;
    if (do_retire) begin
      valid_n[head]    = 1'b0;
      resolved_n[head] = 1'b0;
    end
    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (age[i] > res_age) begin
          valid_n[i]    = 1'b0;
          resolved_n[i] = 1'b0;
        end
      end
    end
  end

  // Retire is applied before the squash: the surviving span runs from the
  // new head up to and including the mispredicted entry.
  always_comb begin
    head_n = head + TAG_W'(do_retire);
    if (mispredict) begin
      tail_n  = bus.resolve_tag + TAG_W'(1);
      count_n = {1'b0, bus.resolve_tag - head_n} + (TAG_W+1)'(1);
    end else begin
      tail_n  = tail + TAG_W'(do_alloc);
      count_n = count_q + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_retire);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid      <= '0;
      ent_resolved   <= '0;
      head           <= '0;
      tail           <= '0;
      count_q        <= '0;
      flush_q        <= 1'b0;
      recover_q      <= '0;
      flush_tag_q    <= '0;
      retire_valid_q <= 1'b0;
      retire_tag_q   <= '0;
    end else begin
      ent_valid      <= valid_n;
      ent_resolved   <= resolved_n;
      head           <= head_n;
      tail           <= tail_n;
      count_q        <= count_n;
      flush_q        <= mispredict;
      retire_valid_q <= do_retire;
      if (do_retire) retire_tag_q <= head;
      if (mispredict) begin
        recover_q   <= bus.resolve_taken ? bus.resolve_target
                                         : sel_pc + PC_WIDTH'(4);
        flush_tag_q <= bus.resolve_tag;
      end
    end
  end

  // Payload carries no reset; it is only read behind a set valid bit.
  always_ff @(posedge clk) begin
    if (do_alloc && !mispredict) begin
      ent_pc[tail]         <= bus.alloc_pc;
      ent_pred_taken[tail] <= bus.alloc_pred_taken;
      ent_target[tail]     <= bus.alloc_pred_target;
    end
  end

  assign bus.alloc_ready  = alloc_ready;
  assign bus.alloc_tag    = tail;
  assign bus.flush        = flush_q;
  assign bus.recover_pc   = recover_q;
  assign bus.flush_tag    = flush_tag_q;
  assign bus.retire_valid = retire_valid_q;
  assign bus.retire_tag   = retire_tag_q;
  assign bus.count        = count_q;
endmodule
